// File: rtl/gesture_pkg.sv
// Shared constants and state encoding for the GestureSpeak word-to-code path.
// Also holds the ASCII case-fold and letter-class helpers.
package gesture_pkg;

  localparam int          MAX_LEN     = 6;
  localparam int          CODE_W      = 4;
  localparam int          NUM_WORDS   = 16;
  localparam int          WORD_W      = MAX_LEN * 8;
  localparam logic [7:0]  TERM_CHAR   = 8'h0D;
  localparam logic [7:0]  BS_CHAR     = 8'h08;
  localparam logic [7:0]  ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    OVERFLOW,
    SCAN,
    EMIT,
    REJECT
  } state_e;

  function automatic logic [7:0] fold_char(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    return c;
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A);
  endfunction

endpackage

// File: rtl/word_to_gesture_if.sv
// Byte-in / code-out bundle between the typed-word source and the resolver.
// master drives bytes and observes results; slave is the resolver side.
interface word_to_gesture_if;
  import gesture_pkg::*;

  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              no_match;
  logic              overflow;
  logic              busy;

  modport master (
    output char_in, char_valid,
    input  char_ready, code_out, code_valid, no_match, overflow, busy
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, code_out, code_valid, no_match, overflow, busy
  );

endinterface

// File: rtl/word_to_gesture_vocab_rom.sv
// GestureSpeak vocabulary: code index to 6-char right-justified, space-padded word.
// Purely combinational; entry 0 is the all-space word and is never a valid code.
module vocab_rom
  import gesture_pkg::*;
(
  input  logic [CODE_W-1:0] idx_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = {MAX_LEN{ASCII_SPACE}};
    case (idx_i)
      4'd1:    word_o = "   YES";
      4'd2:    word_o = "    NO";
      4'd3:    word_o = "  HELP";
      4'd4:    word_o = " WATER";
      4'd5:    word_o = "  FOOD";
      4'd6:    word_o = "  PAIN";
      4'd7:    word_o = "  STOP";
      4'd8:    word_o = "    GO";
      4'd9:    word_o = "  HOME";
      4'd10:   word_o = "HUNGRY";
      4'd11:   word_o = "THIRST";
      4'd12:   word_o = "  CALL";
      4'd13:   word_o = " EMERG";
      4'd14:   word_o = "    OK";
      4'd15:   word_o = "THANKS";
      default: word_o = {MAX_LEN{ASCII_SPACE}};
    endcase
  end

endmodule

// File: rtl/word_to_gesture.sv
// Collects a typed word, case-folds it, then scans the vocabulary one entry
// per cycle and pulses code_valid or no_match. Bytes are refused while resolving.
module word_to_gesture
  import gesture_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  word_to_gesture_if.slave   bus
);

  localparam logic [WORD_W-1:0] BLANK = {MAX_LEN{ASCII_SPACE}};

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [2:0]         count_q, count_d;
  logic               bad_q, bad_d;
  logic               ovf_q, ovf_d;
  logic [CODE_W-1:0]  idx_q, idx_d;
  logic [CODE_W-1:0]  code_q, code_d;

  logic [WORD_W-1:0]  rom_word;
  logic [7:0]         ch;
  logic               xfer, is_term, is_bs;

  vocab_rom u_rom (
    .idx_i  (idx_q),
    .word_o (rom_word)
  );

  assign ch      = fold_char(bus.char_in);
  assign is_term = (bus.char_in == TERM_CHAR);
  assign is_bs   = (bus.char_in == BS_CHAR);
  assign xfer    = bus.char_valid && bus.char_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    bad_d   = bad_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    code_d  = code_q;

    case (state_q)
      IDLE: begin
        if (xfer && !is_term && !is_bs) begin
          buf_d   = {buf_q[WORD_W-9:0], ch};
          count_d = 3'd1;
          bad_d   = bad_q | !is_upper(ch);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (is_term) begin
            idx_d   = 4'd1;
            state_d = bad_q ? REJECT : SCAN;
          end else if (is_bs) begin
            buf_d   = {ASCII_SPACE, buf_q[WORD_W-1:8]};
            count_d = count_q - 3'd1;
            if (count_q == 3'd1) state_d = IDLE;
          end else if (count_q == 3'(MAX_LEN)) begin
            ovf_d   = 1'b1;
            state_d = OVERFLOW;
          end else begin
            buf_d   = {buf_q[WORD_W-9:0], ch};
            count_d = count_q + 3'd1;
            bad_d   = bad_q | !is_upper(ch);
          end
        end
      end
      OVERFLOW: begin
        if (xfer && is_term) state_d = REJECT;
      end
      SCAN: begin
        if (rom_word == buf_q) begin
          code_d  = idx_q;
          state_d = EMIT;
        end else if (idx_q == 4'(NUM_WORDS - 1)) begin
          state_d = REJECT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      EMIT, REJECT: begin
        buf_d   = BLANK;
        count_d = 3'd0;
        bad_d   = 1'b0;
        ovf_d   = 1'b0;
        idx_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= BLANK;
      count_q <= 3'd0;
      bad_q   <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= 4'd0;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

  // code_q is loaded on the hit, so it already shows the new code during EMIT.
  assign bus.code_out   = code_q;
  assign bus.code_valid = (state_q == EMIT);
  assign bus.no_match   = (state_q == REJECT);
  assign bus.overflow   = (state_q == REJECT) && ovf_q;
  assign bus.busy       = (state_q == SCAN) || (state_q == EMIT);
  assign bus.char_ready = (state_q == IDLE) || (state_q == COLLECT) ||
                          (state_q == OVERFLOW);

endmodule

// File: tb/tb_word_to_gesture.sv
// Directed words with hand-computed codes and latencies; a scoreboard queue
// is filled by the driver and drained by a negedge monitor on each result pulse.
module tb_word_to_gesture;

  typedef struct {
    bit         is_hit;
    logic [3:0] code;
    bit         ovf;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   term_cyc;
  int   total;
  int   passed;
  exp_t sb[$];

  word_to_gesture_if bus ();

  word_to_gesture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input bit hit, input int code, input bit ovf, input int lat);
    exp_t e;
    e.is_hit = hit;
    e.code   = 4'(code);
    e.ovf    = ovf;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; leaves again just after a rising edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!bus.char_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    bus.char_in    = b;
    bus.char_valid = 1'b1;
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.char_valid && bus.char_ready && bus.char_in == 8'h0D) term_cyc = cyc;
      if (bus.code_valid || bus.no_match) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("code_valid", int'(bus.code_valid), int'(e.is_hit));
          chk("no_match", int'(bus.no_match), int'(!e.is_hit));
          chk("code_out", int'(bus.code_out), int'(e.code));
          chk("overflow", int'(bus.overflow), int'(e.ovf));
          chk("latency", cyc - term_cyc, e.lat);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code_out"}, int'(bus.code_out), 0);
    chk({tag, "_code_valid"}, int'(bus.code_valid), 0);
    chk({tag, "_no_match"}, int'(bus.no_match), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_char_ready"}, int'(bus.char_ready), 1);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    cyc = 0; term_cyc = 0; total = 0; passed = 0;
    rst = 1'b1;
    bus.char_in = 8'h00;
    bus.char_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // "yes": lowercase folds to entry 1, result two cycles after the CR
    push(1, 1, 0, 2);
    send_str("yes"); send(8'h0D);
    chk("yes_ready_t1", int'(bus.char_ready), 0);
    chk("yes_busy_t1", int'(bus.busy), 1);
    @(posedge clk); #1;
    chk("yes_ready_t2", int'(bus.char_ready), 0);
    @(posedge clk); #1;
    chk("yes_ready_t3", int'(bus.char_ready), 1);

    // last entry, full-width word
    push(1, 15, 0, 16);
    send_str("THANKS"); send(8'h0D);
    chk("thanks_busy", int'(bus.busy), 1);

    // scan miss keeps code_out at 15
    push(0, 15, 0, 16);
    send_str("HELLO"); send(8'h0D);

    // seven characters: overflow reject straight after the CR, then recovery
    push(0, 15, 1, 1);
    send_str("WATERSX"); send(8'h0D);
    push(1, 8, 0, 9);
    send_str("GO"); send(8'h0D);

    // backspace edits, bad character, and lone control bytes
    push(1, 2, 0, 3);
    send_str("NOX"); send(8'h08); send(8'h0D);
    push(0, 2, 0, 1);
    send_str("N1"); send(8'h0D);
    send(8'h0D);
    send(8'h08);
    repeat (20) @(posedge clk);
    #1;

    // reset in the middle of a scan aborts without any pulse
    send_str("HOME"); send(8'h0D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("home_busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    push(1, 14, 0, 15);
    send_str("OK"); send(8'h0D);

    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
